// File: rtl/dcache_mem_pkg.sv
// dcache_mem_pkg: shared types and helpers for the dcache memory-side responder.
//   mem_state_e  - responder FSM states
//   mem_req_t    - captured request (line address, write flag, line data)
//   line_pattern - deterministic contents of a line that has never been written
package dcache_mem_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned BLK_SIZE  = 128;
   localparam int unsigned BOFFSET   = 4;
   localparam int unsigned MEM_IDX_W = 4;
   localparam int unsigned LINES     = 1 << MEM_IDX_W;
   localparam int unsigned WORDS     = BLK_SIZE / 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_e;

   typedef struct packed {
      logic [XLEN-1:0]     addr;
      logic                we;
      logic [BLK_SIZE-1:0] wdata;
   } mem_req_t;

   // Word k of an unwritten line is the byte address of that word, so a fill from
   // untouched memory is self-describing.
   function automatic logic [BLK_SIZE-1:0] line_pattern(input logic [XLEN-1:0] addr);
      logic [XLEN-1:0]     base;
      logic [BLK_SIZE-1:0] line;
      base = {addr[XLEN-1:BOFFSET], {BOFFSET{1'b0}}};
      line = '0;
      for (int unsigned k = 0; k < WORDS; k++) begin
         line[k*32 +: 32] = base + XLEN'(4 * k);
      end
      return line;
   endfunction

endpackage

// File: rtl/dcache_mem_responder_if.sv
// dcache_mem_responder_if: refill/writeback port between the dcache (master) and
// the memory responder (slave).
//   req_*   - one-line request: valid/ready handshake, line address, write flag, data
//   resp_*  - response: valid, ready (backpressure builds only), write echo, line data
//   *_cnt_o - completed fill / writeback statistics
interface dcache_mem_responder_if;
   import dcache_mem_pkg::*;

   logic                req_valid_i;
   logic                req_ready_o;
   logic [XLEN-1:0]     req_addr_i;
   logic                req_we_i;
   logic [BLK_SIZE-1:0] req_wdata_i;
   logic                resp_valid_o;
   logic                resp_ready_i;
   logic                resp_we_o;
   logic [BLK_SIZE-1:0] resp_rdata_o;
   logic [31:0]         rd_cnt_o;
   logic [31:0]         wr_cnt_o;

   modport master (
      output req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_we_o, resp_rdata_o, rd_cnt_o, wr_cnt_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_we_o, resp_rdata_o, rd_cnt_o, wr_cnt_o
   );

endinterface

// File: rtl/dcache_mem_array.sv
// dcache_mem_array: 16-line backing store with per-line written flags.
//   clk_i, rst_ni - clock, asynchronous active-low reset (clears written flags only)
//   wr_en/wr_idx/wr_data - line write port
//   rd_addr/rd_data      - combinational line read; unwritten lines return line_pattern
module dcache_mem_array
   import dcache_mem_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wr_en,
   input  logic [MEM_IDX_W-1:0] wr_idx,
   input  logic [BLK_SIZE-1:0]  wr_data,
   input  logic [XLEN-1:0]      rd_addr,
   output logic [BLK_SIZE-1:0]  rd_data
);

   logic [BLK_SIZE-1:0]  mem_q [LINES];
   logic [LINES-1:0]     written_q;
   logic [MEM_IDX_W-1:0] rd_idx;

   assign rd_idx = rd_addr[BOFFSET+MEM_IDX_W-1:BOFFSET];

   // Data is deliberately unreset; the written flags decide whether it is visible.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         written_q <= '0;
      end else if (wr_en) begin
         written_q[wr_idx] <= 1'b1;
      end
   end

   always_comb begin
      rd_data = written_q[rd_idx] ? mem_q[rd_idx] : line_pattern(rd_addr);
   end

endmodule

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: memory-side model answering dcache line fills and dirty-line
// writebacks with a fixed latency, one request outstanding at a time.
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset; aborts any transaction in flight
//   bus    - dcache_mem_responder_if.slave (request, response, fill/writeback counters)
// Build option: define DCACHE_MEM_BACKPRESSURE_EN to hold the response until
// resp_ready_i; otherwise the response is a single-cycle pulse and resp_ready_i is ignored.
module dcache_mem_responder
   import dcache_mem_pkg::*;
#(
   parameter int unsigned LATENCY = 3
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   dcache_mem_responder_if.slave bus
);

   localparam int unsigned CntW = 8;

   mem_state_e          state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   mem_req_t            req_q, in_req, cur_req;
   logic [BLK_SIZE-1:0] rdata_q, rd_data;
   logic [31:0]         rd_cnt_q, wr_cnt_q;
   logic                accept, load_resp, complete;

   assign in_req = '{addr: bus.req_addr_i, we: bus.req_we_i, wdata: bus.req_wdata_i};
   assign accept = (state_q == IDLE) && bus.req_valid_i;
   // With LATENCY=1 the response is loaded on the acceptance edge, before req_q holds it.
   assign cur_req = (state_q == IDLE) ? in_req : req_q;

`ifdef DCACHE_MEM_BACKPRESSURE_EN
   assign complete = (state_q == RESP) && bus.resp_ready_i;
`else
   logic unused_resp_ready;
   assign unused_resp_ready = bus.resp_ready_i;
   assign complete = (state_q == RESP);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      load_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d   = RESP;
                  load_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q <= CntW'(1)) begin
               state_d   = RESP;
               load_resp = 1'b1;
            end
         end
         RESP: begin
            if (complete) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = CntW'(LATENCY - 1);
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         req_q    <= '0;
         rdata_q  <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            req_q <= in_req;
         end
         if (load_resp) begin
            rdata_q <= cur_req.we ? cur_req.wdata : rd_data;
         end
         if (complete) begin
            if (req_q.we) begin
               wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
               rd_cnt_q <= rd_cnt_q + 32'd1;
            end
         end
      end
   end

   dcache_mem_array u_array (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_en   (accept && bus.req_we_i),
      .wr_idx  (bus.req_addr_i[BOFFSET+MEM_IDX_W-1:BOFFSET]),
      .wr_data (bus.req_wdata_i),
      .rd_addr (cur_req.addr),
      .rd_data (rd_data)
   );

   always_comb begin
      bus.req_ready_o  = (state_q == IDLE);
      bus.resp_valid_o = (state_q == RESP);
      bus.resp_we_o    = (state_q == RESP) && req_q.we;
      bus.resp_rdata_o = rdata_q;
      bus.rd_cnt_o     = rd_cnt_q;
      bus.wr_cnt_o     = wr_cnt_q;
   end

   // The countdown is 8 bits wide and needs at least one cycle of latency.
   latency_range_a: assert property (@(posedge clk_i) (LATENCY >= 1 && LATENCY <= 255))
      else $error("dcache_mem_responder: LATENCY=%0d outside 1..255", LATENCY);

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder: directed, table-driven bench for dcache_mem_responder
// (LATENCY=3) plus hand-written sequences for busy rejection, response
// backpressure and reset during a transaction.
module tb_dcache_mem_responder;
   import dcache_mem_pkg::*;

   localparam int unsigned LAT = 3;

   typedef struct {
      logic [31:0]  addr;
      logic         we;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   logic [31:0] exp_rd = '0;
   logic [31:0] exp_wr = '0;

   always #5 clk = ~clk;

   dcache_mem_responder_if bus ();

   dcache_mem_responder #(.LATENCY(LAT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts at a negedge; returns at the negedge where resp_valid_o is first seen.
   task automatic xact(input logic [31:0] addr, input logic we, input logic [127:0] wdata,
                       output logic [127:0] rdata, output logic rwe, output int lat,
                       output logic busy_ok);
      int n = 0;
      while (!bus.req_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      bus.req_addr_i  = addr;
      bus.req_we_i    = we;
      bus.req_wdata_i = wdata;
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      // Scramble the inputs: the captured request must not follow them.
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = ~addr;
      bus.req_we_i    = ~we;
      bus.req_wdata_i = ~wdata;
      lat     = 0;
      busy_ok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (bus.req_ready_o) busy_ok = 1'b0;
      end while (!bus.resp_valid_o && lat < 300);
      rdata = bus.resp_rdata_o;
      rwe   = bus.resp_we_o;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected test done");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t         vecs [9];
      logic [127:0] rdata;
      logic         rwe;
      logic         busy_ok;
      int           lat;
      int           acc [$];
      int           nvalid;

      vecs[0] = '{32'h0000_0020, 1'b0, 128'h0, 128'h0000002C_00000028_00000024_00000020};
      vecs[1] = '{32'h0000_0040, 1'b1, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,
                  128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0};
      vecs[2] = '{32'h0000_0044, 1'b0, 128'h0, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0};
      vecs[3] = '{32'h0000_0010, 1'b1, 128'h11112222_33334444_55556666_77778888,
                  128'h11112222_33334444_55556666_77778888};
      vecs[4] = '{32'h0000_0110, 1'b0, 128'h0, 128'h11112222_33334444_55556666_77778888};
      vecs[5] = '{32'h1234_5678, 1'b0, 128'h0, 128'h1234567C_12345678_12345674_12345670};
      vecs[6] = '{32'hFFFF_FFF0, 1'b0, 128'h0, 128'hFFFFFFFC_FFFFFFF8_FFFFFFF4_FFFFFFF0};
      vecs[7] = '{32'h0000_0070, 1'b1, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                  128'h01234567_89ABCDEF_FEDCBA98_76543210};
      vecs[8] = '{32'h1234_5678, 1'b0, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210};

      rst_n            = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_addr_i   = '0;
      bus.req_we_i     = 1'b0;
      bus.req_wdata_i  = '0;
      bus.resp_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      check("rst req_ready", 128'(bus.req_ready_o), 128'(1));
      check("rst resp_valid", 128'(bus.resp_valid_o), 128'(0));
      check("rst resp_we", 128'(bus.resp_we_o), 128'(0));
      check("rst resp_rdata", bus.resp_rdata_o, 128'h0);
      check("rst rd_cnt", 128'(bus.rd_cnt_o), 128'(0));
      check("rst wr_cnt", 128'(bus.wr_cnt_o), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         xact(vecs[i].addr, vecs[i].we, vecs[i].wdata, rdata, rwe, lat, busy_ok);
         check($sformatf("v%0d latency", i), 128'(lat), 128'(LAT));
         check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d resp_we", i), 128'(rwe), 128'(vecs[i].we));
         check($sformatf("v%0d ready low while busy", i), 128'(busy_ok), 128'(1));
         if (vecs[i].we) exp_wr++;
         else exp_rd++;
         @(negedge clk);
         check($sformatf("v%0d valid pulse end", i), 128'(bus.resp_valid_o), 128'(0));
         check($sformatf("v%0d rd_cnt", i), 128'(bus.rd_cnt_o), 128'(exp_rd));
         check($sformatf("v%0d wr_cnt", i), 128'(bus.wr_cnt_o), 128'(exp_wr));
      end

      // Continuous request: acceptances exactly LAT+1 cycles apart.
      bus.req_addr_i  = 32'h0000_0020;
      bus.req_we_i    = 1'b0;
      bus.req_valid_i = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready_o) acc.push_back(i);
         if (bus.resp_valid_o) nvalid++;
         @(negedge clk);
      end
      bus.req_valid_i = 1'b0;
      check("busy accept count", 128'(acc.size()), 128'(5));
      for (int j = 1; j < acc.size(); j++) begin
         check($sformatf("busy spacing %0d", j), 128'(acc[j] - acc[j-1]), 128'(LAT + 1));
      end
      check("busy resp count", 128'(nvalid), 128'(5));
      exp_rd += 5;
      repeat (2) @(negedge clk);
      check("busy rd_cnt", 128'(bus.rd_cnt_o), 128'(exp_rd));

      // Response with resp_ready_i low.
      bus.resp_ready_i = 1'b0;
      xact(32'h0000_0048, 1'b0, 128'h0, rdata, rwe, lat, busy_ok);
      check("bp latency", 128'(lat), 128'(LAT));
      check("bp rdata", rdata, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
`ifdef DCACHE_MEM_BACKPRESSURE_EN
      for (int j = 0; j < 5; j++) begin
         check($sformatf("bp hold valid %0d", j), 128'(bus.resp_valid_o), 128'(1));
         check($sformatf("bp hold data %0d", j), bus.resp_rdata_o,
               128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
         check($sformatf("bp hold rd_cnt %0d", j), 128'(bus.rd_cnt_o), 128'(exp_rd));
         @(negedge clk);
      end
      bus.resp_ready_i = 1'b1;
      @(negedge clk);
      exp_rd++;
      check("bp release valid", 128'(bus.resp_valid_o), 128'(0));
      check("bp release rd_cnt", 128'(bus.rd_cnt_o), 128'(exp_rd));
`else
      @(negedge clk);
      exp_rd++;
      check("no-bp pulse end", 128'(bus.resp_valid_o), 128'(0));
      check("no-bp rd_cnt", 128'(bus.rd_cnt_o), 128'(exp_rd));
      bus.resp_ready_i = 1'b1;
`endif

      // Reset during WAIT of a write: the write is lost, no response appears.
      @(negedge clk);
      bus.req_addr_i  = 32'h0000_0030;
      bus.req_we_i    = 1'b1;
      bus.req_wdata_i = 128'hAAAA5555_AAAA5555_AAAA5555_AAAA5555;
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_rd = '0;
      exp_wr = '0;
      check("midrst resp_valid", 128'(bus.resp_valid_o), 128'(0));
      check("midrst req_ready", 128'(bus.req_ready_o), 128'(1));
      check("midrst rd_cnt", 128'(bus.rd_cnt_o), 128'(exp_rd));
      check("midrst wr_cnt", 128'(bus.wr_cnt_o), 128'(exp_wr));
      @(negedge clk);
      rst_n = 1'b1;
      nvalid = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.resp_valid_o) nvalid++;
      end
      check("midrst no response", 128'(nvalid), 128'(0));
      check("midrst wr_cnt after", 128'(bus.wr_cnt_o), 128'(0));
      xact(32'h0000_0030, 1'b0, 128'h0, rdata, rwe, lat, busy_ok);
      check("midrst read pattern", rdata, 128'h0000003C_00000038_00000034_00000030);
      check("midrst read latency", 128'(lat), 128'(LAT));
      @(negedge clk);
      exp_rd++;
      check("midrst read rd_cnt", 128'(bus.rd_cnt_o), 128'(exp_rd));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the 2-way write-back dcache's refill/writeback port. It answers line-fill reads and dirty-line writebacks.
- Used in dcache_tb as the lower level of the hierarchy, in place of a real memory/bus.
- Holds one outstanding request, applies a fixed programmable latency and returns whole 128-bit lines.
- Exposes fill/writeback counters so the bench can cross-check the model's eviction decisions.

Parameters:
- XLEN, 32, address width
- BLK_SIZE, 128, cache line width in bits
- BOFFSET, 4, log2(BLK_SIZE/8), byte offset within a line
- MEM_IDX_W, 4, log2 of backing lines (16 lines); upper address bits alias
- LATENCY, 3, cycles from request acceptance to resp_valid_o; legal range 1..255

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  responder can accept a request
- req_addr_i  in  XLEN  line address; bits [BOFFSET-1:0] ignored
- req_we_i  in  1  1 = writeback, 0 = fill read
- req_wdata_i  in  BLK_SIZE  writeback line data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response accept; used only with DCACHE_MEM_BACKPRESSURE_EN
- resp_we_o  out  1  echo of the request's req_we_i
- resp_rdata_o  out  BLK_SIZE  fill data (reads) or echo of written line (writes)
- rd_cnt_o  out  32  completed fills, wraps at 2^32
- wr_cnt_o  out  32  completed writebacks, wraps at 2^32

Behaviour:
- Reset values:
  - req_ready_o=1, resp_valid_o=0, resp_we_o=0, resp_rdata_o=0, counters=0.
  - FSM=IDLE, latency counter=0, written[] bits all 0.
  - Storage data is not reset.
- Line index = req_addr_i[BOFFSET+MEM_IDX_W-1:BOFFSET].
- Read of a line whose written bit is 0 returns a deterministic pattern:
  - 32-bit word k (k=0..3, LSB first) = {req_addr_i[XLEN-1:BOFFSET], BOFFSET'b0} + 4*k.
- Read of a line whose written bit is 1 returns the stored line.
- FSM IDLE:
  - req_ready_o=1.
  - On req_valid_i && req_ready_o, capture addr/we/wdata, load the counter with LATENCY-1 and go to WAIT (LATENCY=1 goes directly to RESP).
  - Writes commit to storage and set the written bit on this acceptance edge.
- FSM WAIT:
  - req_ready_o=0. Decrement the counter.
  - When it reaches 0, register resp_rdata_o from storage/pattern (or the written line) and go to RESP.
  - Net effect: resp_valid_o rises exactly LATENCY cycles after the acceptance edge.
- FSM RESP:
  - resp_valid_o=1, resp_we_o=captured we.
  - Response completes (macro rules below); on completion increment rd_cnt_o or wr_cnt_o and return to IDLE.
- Request/response overlap:
  - req_ready_o is 0 throughout WAIT and RESP; req_valid_i is ignored there.
  - Minimum spacing between acceptances is LATENCY+1 cycles.
- Once accepted, the captured request is stable; changes on req_* inputs after acceptance have no effect.
- Reset asserted mid-transaction:
  - Aborts immediately and returns the FSM to IDLE. No response is issued.
  - Counters and written bits are cleared. A write accepted before the reset is considered lost.
- Counter increment at 0xFFFF_FFFF wraps to 0.
- Simulation assertion fires if LATENCY==0 or LATENCY>255.

Optional Feature:
- Macro DCACHE_MEM_BACKPRESSURE_EN.
- Defined: RESP holds resp_valid_o and resp_rdata_o stable until resp_ready_i=1; completion occurs on the edge where both are high.
- Undefined: resp_valid_o is a single-cycle pulse and completion is unconditional in RESP; resp_ready_i is ignored. The cache must sink the response.

Decomposition:
- Package dcache_mem_pkg holds:
  - state enum mem_state_e {IDLE, WAIT, RESP}
  - packed struct mem_req_t {addr, we, wdata}
  - function line_pattern(addr) producing the unwritten-line pattern
- Sub-module dcache_mem_array holds the data storage and written[] bits: write port on acceptance, combinational read with pattern fallback.
- The responder keeps the FSM, latency counter and statistics.

Test Plan:
- Unwritten-line fill:
  - Reset, LATENCY=3, read 0x0000_0020.
  - Expect resp_valid_o 3 cycles after acceptance, resp_rdata_o=0x0000002C_00000028_00000024_00000020, rd_cnt_o=1.
- Writeback then fill:
  - Write 0x0000_0040 with line 0xDEADBEEF_CAFEF00D_12345678_9ABCDEF0, then read 0x0000_0044.
  - Expect the same line back (offset ignored), wr_cnt_o=1, rd_cnt_o=1.
- Aliasing:
  - Write 0x0000_0010 (index 1), read 0x0000_0110 (index 1).
  - Expect the written line, not the pattern.
- Busy rejection:
  - Hold req_valid_i high continuously.
  - Acceptances exactly LATENCY+1 cycles apart; req_ready_o=0 during WAIT/RESP.
- Backpressure (macro on):
  - Keep resp_ready_i=0 for 5 cycles.
  - resp_valid_o and data held stable, counter unchanged; completes on the cycle resp_ready_i=1.
- Reset mid-op:
  - Assert rst_ni low during WAIT of a write to 0x0000_0030.
  - No resp_valid_o, counters 0; a subsequent read of 0x0000_0030 returns pattern 0x0000003C_00000038_00000034_00000030.
